// File: rtl/varredura_display.sv
// -----------------------------------------------------------------------------
// varredura_display
//
// Scan controller for a 4-digit multiplexed 7-segment display. It produces the
// 2-bit digit select (chave1:chave0) for the downstream 16-to-4 digit mux and
// the matching anode enables. Each digit owns a slot of DIVISOR clocks. The
// first BLANK clocks of a slot keep every anode dark to suppress ghosting.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   habilita        in   global scan enable (0 = freeze scan, anodes dark)
//   mascara[3:0]    in   per-digit enable, bit i gates digit i
//   chave0          out  digit select LSB (registered digit)
//   chave1          out  digit select MSB (registered digit)
//   outAnodo[3:0]   out  anode enables, polarity set by ANODO_ATIVO_BAIXO
//   outFimVarredura out  one-cycle pulse after digit 3 wraps back to digit 0
//
// Every output comes straight from a flop. The anode register is loaded from
// the next-state values of the counter and digit, so it always agrees with
// the state registers in the same cycle.
// -----------------------------------------------------------------------------
module varredura_display #(
   parameter int DIVISOR           = 50000,
   parameter int BLANK             = 1000,
   parameter int ANODO_ATIVO_BAIXO = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] mascara,
   output logic       chave0,
   output logic       chave1,
   output logic [3:0] outAnodo,
   output logic       outFimVarredura
);

   localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
   localparam logic [3:0]    INATIVO = (ANODO_ATIVO_BAIXO != 0) ? 4'b1111 : 4'b0000;

   typedef enum logic {APAGA = 1'b0, EXIBE = 1'b1} fase_t;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digito_q, digito_d;
   fase_t         fase_q, fase_d;
   logic [3:0]    anodo_q, anodo_d;
   logic          fim_q, fim_d;
   logic          em_branco;   // next counter value falls inside the blanking window
   logic [3:0]    um_quente;

   // With BLANK = 0 the comparison would be against zero and always false;
   // keep it out of the netlist entirely in that case.
   generate
      if (BLANK == 0) begin : g_sem_branco
         assign em_branco = 1'b0;
      end else begin : g_com_branco
         localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
         assign em_branco = (cnt_d < BLANK_C);
      end
   endgenerate

   always_comb begin
      cnt_d    = cnt_q;
      digito_d = digito_q;
      fim_d    = 1'b0;
      if (habilita) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            digito_d = digito_q + 2'd1;
            fim_d    = (digito_q == 2'd3);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      fase_d    = em_branco ? APAGA : EXIBE;
      um_quente = 4'b0001 << digito_d;
      anodo_d   = INATIVO;
      // When disabled the phase register still follows the (held) counter,
      // but the anodes are forced dark.
      if (habilita && (fase_d == EXIBE) && mascara[digito_d]) begin
         anodo_d = INATIVO ^ um_quente;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         digito_q <= 2'd0;
         fase_q   <= APAGA;
         anodo_q  <= INATIVO;
         fim_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         digito_q <= digito_d;
         fase_q   <= fase_d;
         anodo_q  <= anodo_d;
         fim_q    <= fim_d;
      end
   end

   assign chave0          = digito_q[0];
   assign chave1          = digito_q[1];
   assign outAnodo        = anodo_q;
   assign outFimVarredura = fim_q;

   // The phase register mirrors the anode gating; it is kept as explicit
   // state for visibility when debugging the scan.
   logic fase_nao_usada;
   assign fase_nao_usada = (fase_q == EXIBE);

endmodule
